// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared constants and element types for the MVM dot-product/accumulator path
//
// Purpose : element/product/result widths, lane count and pipeline latency of dot8.
// Ports   : none (package).
// Config  : DOT8_INREG_EN - when defined, dot8 carries an extra input register
//           stage and DOT8_LAT grows by one.
package mvm_pkg;

    localparam int IWIDTH = 8;
    localparam int LANES  = 8;
    localparam int LEVELS = $clog2(LANES);
    localparam int OWIDTH = 2 * IWIDTH + LEVELS;

`ifdef DOT8_INREG_EN
    localparam int DOT8_LAT = 2 + LEVELS;
`else
    localparam int DOT8_LAT = 1 + LEVELS;
`endif

    typedef logic signed [IWIDTH-1:0]   elem_t;
    typedef logic signed [2*IWIDTH-1:0] prod_t;
    typedef logic signed [OWIDTH-1:0]   dot_t;

endpackage

// File: rtl/add_level.sv
// rtl/add_level.sv - one registered level of the dot8 adder tree
//
// Purpose : adds adjacent pairs of N signed W-bit inputs into N/2 signed
//           (W+1)-bit sums, registered, cleared by reset.
// Ports   : clk  - clock, rising edge
//           rst  - synchronous active-high reset
//           din  - N packed signed operands, operand i in [i*W +: W]
//           dout - N/2 packed signed sums, sum i in [i*(W+1) +: W+1]
module add_level #(
    parameter int N = 2,
    parameter int W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N*W-1:0]           din,
    output logic [(N/2)*(W+1)-1:0]   dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            for (int i = 0; i < N / 2; i++) begin
                // Sign-extend each operand by one bit so the sum never wraps.
                dout[i*(W+1) +: (W+1)] <=
                    {din[(2*i)*W + W - 1],   din[(2*i)*W +: W]} +
                    {din[(2*i+1)*W + W - 1], din[(2*i+1)*W +: W]};
            end
        end
    end

endmodule

// File: rtl/dot8.sv
// rtl/dot8.sv - pipelined signed LANES-wide dot product with first/last tag forwarding
//
// Purpose : per cycle multiplies one vector slice by one matrix-row slice
//           lane-wise and reduces through a registered adder tree; tags ride a
//           matching shift register so results stay aligned for the accumulator.
// Ports   : clk       - clock, rising edge
//           rst       - synchronous active-high reset, flushes everything in flight
//           vec, mat  - LANES packed signed IWIDTH elements, lane i in [i*IWIDTH +: IWIDTH]
//           ivalid    - vec/mat/tags valid this cycle
//           first     - slice opens a row (qualified by ivalid)
//           last      - slice closes a row (qualified by ivalid)
//           result    - signed OWIDTH dot product
//           ovalid    - result and tags valid
//           first_out - delayed first, zero whenever ovalid is zero
//           last_out  - delayed last, zero whenever ovalid is zero
// Config  : DOT8_INREG_EN - adds a reset-cleared input register stage (+1 cycle latency).
module dot8
    import mvm_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*IWIDTH-1:0]   vec,
    input  logic [LANES*IWIDTH-1:0]   mat,
    input  logic                      ivalid,
    input  logic                      first,
    input  logic                      last,
    output logic signed [OWIDTH-1:0]  result,
    output logic                      ovalid,
    output logic                      first_out,
    output logic                      last_out
);

    localparam int PW = 2 * IWIDTH;
    localparam int VL = 1 + LEVELS;   // stage M plus one stage per tree level

    logic [LANES*IWIDTH-1:0] vec_s;
    logic [LANES*IWIDTH-1:0] mat_s;
    logic                    ivalid_s;
    logic                    first_s;
    logic                    last_s;

`ifdef DOT8_INREG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_s    <= '0;
            mat_s    <= '0;
            ivalid_s <= 1'b0;
            first_s  <= 1'b0;
            last_s   <= 1'b0;
        end else begin
            vec_s    <= vec;
            mat_s    <= mat;
            ivalid_s <= ivalid;
            first_s  <= first;
            last_s   <= last;
        end
    end
`else
    assign vec_s    = vec;
    assign mat_s    = mat;
    assign ivalid_s = ivalid;
    assign first_s  = first;
    assign last_s   = last;
`endif

    // Stage M: lane products. Data registers load every cycle; only the tag
    // pipe decides whether a result is meaningful.
    logic [LANES*PW-1:0] prod_flat;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_flat <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                prod_flat[i*PW +: PW] <=
                    prod_t'(elem_t'(vec_s[i*IWIDTH +: IWIDTH])) *
                    prod_t'(elem_t'(mat_s[i*IWIDTH +: IWIDTH]));
            end
        end
    end

    // Stages A1..Ak: level j reduces LANES>>j operands of width PW+j.
    for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
        localparam int N = LANES >> j;
        localparam int W = PW + j;

        logic [N*W-1:0]         din;
        logic [(N/2)*(W+1)-1:0] sum;

        if (j == 0) begin : g_src
            assign din = prod_flat;
        end else begin : g_src
            assign din = g_lvl[j-1].sum;
        end

        add_level #(
            .N (N),
            .W (W)
        ) u_add_level (
            .clk  (clk),
            .rst  (rst),
            .din  (din),
            .dout (sum)
        );
    end

    assign result = g_lvl[LEVELS-1].sum;

    // Tag pipe: tags are qualified by ivalid on entry, so stale first/last
    // can never surface without ovalid.
    logic [VL-1:0] v_pipe;
    logic [VL-1:0] f_pipe;
    logic [VL-1:0] l_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
            f_pipe <= '0;
            l_pipe <= '0;
        end else begin
            v_pipe <= {v_pipe[VL-2:0], ivalid_s};
            f_pipe <= {f_pipe[VL-2:0], first_s & ivalid_s};
            l_pipe <= {l_pipe[VL-2:0], last_s & ivalid_s};
        end
    end

    assign ovalid    = v_pipe[VL-1];
    assign first_out = f_pipe[VL-1];
    assign last_out  = l_pipe[VL-1];

endmodule

// File: tb/tb_dot8.sv
// tb/tb_dot8.sv - directed self-checking bench for dot8
module tb_dot8;
    import mvm_pkg::*;

    localparam int L    = DOT8_LAT;
    localparam int NCYC = 256;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [LANES*IWIDTH-1:0]  vec = '0;
    logic [LANES*IWIDTH-1:0]  mat = '0;
    logic                     ivalid = 1'b0;
    logic                     first = 1'b0;
    logic                     last = 1'b0;
    logic signed [OWIDTH-1:0] result;
    logic                     ovalid;
    logic                     first_out;
    logic                     last_out;

    dot8 dut (
        .clk       (clk),
        .rst       (rst),
        .vec       (vec),
        .mat       (mat),
        .ivalid    (ivalid),
        .first     (first),
        .last      (last),
        .result    (result),
        .ovalid    (ovalid),
        .first_out (first_out),
        .last_out  (last_out)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit zero_chk   = 1'b1;

    logic                     exp_v [0:NCYC-1];
    logic signed [OWIDTH-1:0] exp_r [0:NCYC-1];
    logic                     exp_f [0:NCYC-1];
    logic                     exp_l [0:NCYC-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, $signed(got), $signed(want));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        chk("ovalid", 32'(ovalid), 32'(exp_v[cyc]));
        chk("first_out", 32'(first_out), 32'(exp_f[cyc]));
        chk("last_out", 32'(last_out), 32'(exp_l[cyc]));
        if (exp_v[cyc]) chk("result", result, exp_r[cyc]);
        if (zero_chk) chk("result_zero", result, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [LANES*IWIDTH-1:0] v, input logic [LANES*IWIDTH-1:0] m,
                        input logic f, input logic l, input int want);
        vec = v; mat = m; ivalid = 1'b1; first = f; last = l;
        zero_chk = 1'b0;
        exp_v[cyc+L] = 1'b1;
        exp_r[cyc+L] = OWIDTH'(want);
        exp_f[cyc+L] = f;
        exp_l[cyc+L] = l;
        tick();
        vec = '0; mat = '0; ivalid = 1'b0; first = 1'b0; last = 1'b0;
    endtask

    // Everything in flight is discarded by reset; a slice offered while rst is
    // high (drop=1) must also vanish.
    task automatic do_reset(input int n, input bit drop);
        for (int k = cyc + 1; k < NCYC; k++) begin
            exp_v[k] = 1'b0; exp_f[k] = 1'b0; exp_l[k] = 1'b0;
        end
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (drop && i == 0) begin
                vec = {LANES{8'h05}}; mat = {LANES{8'h05}};
                ivalid = 1'b1; first = 1'b1; last = 1'b1;
            end
            tick();
            vec = '0; mat = '0; ivalid = 1'b0; first = 1'b0; last = 1'b0;
        end
        rst = 1'b0;
        zero_chk = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NCYC; k++) begin
            exp_v[k] = 1'b0; exp_r[k] = '0; exp_f[k] = 1'b0; exp_l[k] = 1'b0;
        end

        // Reset: outputs zero during and after reset until the first valid.
        do_reset(3, 1'b0);
        idle(3);

        // Single slice: all-ones times 1..8.
        send({LANES{8'h01}}, 64'h0807060504030201, 1'b1, 1'b1, 36);
        idle(L + 1);

        // Signed extremes.
        send({LANES{8'h80}}, {LANES{8'h80}}, 1'b1, 1'b1, 131072);
        send({LANES{8'h80}}, {LANES{8'h7f}}, 1'b1, 1'b1, -130048);
        idle(L);

        // Streaming row: vec=k, mat=1.
        send({LANES{8'h01}}, {LANES{8'h01}}, 1'b1, 1'b0, 8);
        send({LANES{8'h02}}, {LANES{8'h01}}, 1'b0, 1'b0, 16);
        send({LANES{8'h03}}, {LANES{8'h01}}, 1'b0, 1'b0, 24);
        send({LANES{8'h04}}, {LANES{8'h01}}, 1'b0, 1'b1, 32);
        idle(L);

        // Bubble pattern 1,0,1.
        send({LANES{8'h02}}, {LANES{8'h03}}, 1'b1, 1'b0, 48);
        idle(1);
        send({LANES{8'hff}}, {LANES{8'h05}}, 1'b0, 1'b1, -40);
        idle(L);

        // Tags without ivalid are ignored.
        first = 1'b1; last = 1'b1;
        tick();
        first = 1'b0; last = 1'b0;
        idle(L + 1);

        // Mid-flight reset flushes three slices and drops a slice offered during reset.
        send({LANES{8'h01}}, 64'h0807060504030201, 1'b1, 1'b0, 36);
        send({LANES{8'h01}}, 64'h0807060504030201, 1'b0, 1'b0, 36);
        send({LANES{8'h01}}, 64'h0807060504030201, 1'b0, 1'b1, 36);
        do_reset(2, 1'b1);
        idle(L + 2);

        // Fresh slice after reset, mixed signs: 1-4+9-16+25-36+49-64.
        send(64'hF807FA05FC03FE01, 64'h0807060504030201, 1'b1, 1'b1, -36);
        idle(L + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
